ones_checksum_checker: RTL and testbench

Receive-side partner to the team's ones' complement arithmetic. It accepts a stream of WIDTH-bit words over a valid/ready handshake and accumulates them with end-around carry. A transmitter has already appended the complemented checksum word to each frame. On the frame's last word the block reports whether the running ones' complement sum equals all-ones (negative zero), which means the frame is intact. It sits between a nibble/word stream source and downstream frame-acceptance logic.

---
 rtl/ones_pkg.sv | 39 +++
 rtl/ones_add_step.sv | 22 ++
 rtl/ones_checksum_checker.sv | 118 +++++++++++
 tb/tb_ones_checksum_checker.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ones_pkg.sv
`default_nettype none
// ============================================================================
// Module : ones_pkg
// Brief  : Shared types and helpers for ones' complement checksum blocks.
// Rev    : 1.0  initial release
// ============================================================================
package ones_pkg;

    typedef enum logic [0:0] {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } state_t;

    // Ceiling log2; used to size counters from their maximum value.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Low `width` bits set; callers cast to their own word width.
    function automatic logic [63:0] all_ones(input int width);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage : ones_pkg
`default_nettype wire

// File: rtl/ones_add_step.sv
`default_nettype none
// ============================================================================
// Module : ones_add_step
// Brief  : Combinational WIDTH-bit ones' complement add with end-around carry.
// Rev    : 1.0  initial release
// ============================================================================
module ones_add_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    // Folding the carry back in cannot overflow again: max is 2*(2^W-1).
    assign o_y   = w_sum[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};

endmodule : ones_add_step
`default_nettype wire

// File: rtl/ones_checksum_checker.sv
`default_nettype none
// ============================================================================
// Module : ones_checksum_checker
// Brief  : Accumulates a framed word stream and flags a negative-zero total.
// Rev    : 1.0  initial release
// ============================================================================
module ones_checksum_checker
    import ones_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int MAX_WORDS = 15,
    localparam int CW        = clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ok,
    output logic [WIDTH-1:0] res_sum,
    output logic [CW-1:0]    res_count,
    output logic             res_err
);

    localparam logic [WIDTH-1:0] c_ALL_ONES = WIDTH'(all_ones(WIDTH));
    localparam logic [CW-1:0]    c_MAX      = CW'(MAX_WORDS);

    state_t             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [CW-1:0]      r_count;
    logic               r_err;
    logic               r_in_ready;
    logic               r_res_valid;
    logic               r_res_ok;
    logic [WIDTH-1:0]   r_res_sum;
    logic [CW-1:0]      r_res_count;
    logic               r_res_err;

    logic               w_accept;
    logic               w_at_max;
    logic [WIDTH-1:0]   w_acc_next;
    logic [CW-1:0]      w_count_next;
    logic               w_err_next;

    ones_add_step #(
        .WIDTH (WIDTH)
    ) u_add_step (
        .i_a (r_acc),
        .i_b (in_data),
        .o_y (w_acc_next)
    );

    assign w_accept     = in_valid && r_in_ready;
    assign w_at_max     = (r_count == c_MAX);
    assign w_count_next = w_at_max ? r_count : (r_count + CW'(1));
    // Error is sticky: any word arriving with the counter already full.
    assign w_err_next   = r_err | w_at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_ok    <= 1'b0;
            r_res_sum   <= '0;
            r_res_count <= '0;
            r_res_err   <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_acc_next;
                        r_count <= w_count_next;
                        r_err   <= w_err_next;
                        if (in_last) begin
                            r_state     <= RESULT;
                            r_in_ready  <= 1'b0;
                            r_res_valid <= 1'b1;
                            r_res_sum   <= w_acc_next;
                            r_res_count <= w_count_next;
                            r_res_err   <= w_err_next;
                            r_res_ok    <= (w_acc_next == c_ALL_ONES) && !w_err_next;
                        end
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        r_state     <= ACCUM;
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_err       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ACCUM;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign res_valid = r_res_valid;
    assign res_ok    = r_res_ok;
    assign res_sum   = r_res_sum;
    assign res_count = r_res_count;
    assign res_err   = r_res_err;

endmodule : ones_checksum_checker
`default_nettype wire

// File: tb/tb_ones_checksum_checker.sv
`default_nettype none
// ============================================================================
// Module : tb_ones_checksum_checker
// Brief  : Directed and random frames checked against an arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ones_checksum_checker;

    localparam int W    = 4;
    localparam int MAXW = 15;
    localparam int CW   = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_last   = 1'b0;
    logic [W-1:0]  in_data   = '0;
    logic          res_ready = 1'b0;
    logic          in_ready;
    logic          res_valid;
    logic          res_ok;
    logic [W-1:0]  res_sum;
    logic [CW-1:0] res_count;
    logic          res_err;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  q[$];

    ones_checksum_checker #(
        .WIDTH     (W),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ok    (res_ok),
        .res_sum   (res_sum),
        .res_count (res_count),
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ones' complement sum of the whole frame: integer total folded mod 2^W-1.
    function automatic logic [W-1:0] ref_sum();
        int unsigned t;
        t = 0;
        foreach (q[i]) t += q[i];
        while (t > ((1 << W) - 1)) t = (t & ((1 << W) - 1)) + (t >> W);
        return W'(t);
    endfunction

    task automatic send(input logic [W-1:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("accept_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input int hold);
        logic [W-1:0]  e_sum;
        logic [CW-1:0] e_cnt;
        logic          e_err;
        logic          e_ok;
        for (int i = 0; i < q.size(); i++) send(q[i], i == q.size() - 1);
        e_sum = ref_sum();
        e_err = (q.size() > MAXW);
        e_cnt = e_err ? CW'(MAXW) : CW'(q.size());
        e_ok  = (e_sum == {W{1'b1}}) && !e_err;
        chk("res_valid", res_valid, 1'b1);
        chk("in_ready_busy", in_ready, 1'b0);
        chk("res_sum", res_sum, e_sum);
        chk("res_count", res_count, e_cnt);
        chk("res_err", res_err, e_err);
        chk("res_ok", res_ok, e_ok);
        // Drive junk words while stalled; they must be ignored.
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk);
            #1;
            chk("hold_valid", res_valid, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_sum", res_sum, e_sum);
            chk("hold_count", res_count, e_cnt);
            chk("hold_ok", res_ok, e_ok);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("post_valid", res_valid, 1'b0);
        chk("post_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        int n;
        logic [W-1:0] ck;

        #12;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_ok", res_ok, 1'b0);
        chk("rst_res_sum", res_sum, 4'h0);
        chk("rst_res_count", res_count, 4'h0);
        chk("rst_res_err", res_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        q = '{4'h3, 4'h5, 4'h7};        run_frame(0);
        q = '{4'h9, 4'h8};              run_frame(0);
        q = '{4'h6, 4'hA, 4'hE};        run_frame(0);
        q = '{4'h1, 4'h2};              run_frame(5);
        q = '{4'hF};                    run_frame(0);
        q = '{4'h0, 4'h0, 4'h0};        run_frame(0);
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(4'h1);
        run_frame(1);

        // Asynchronous reset mid-frame, applied away from any clock edge.
        send(4'h4, 1'b0);
        send(4'h2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_res_valid", res_valid, 1'b0);
        chk("mid_rst_res_ok", res_ok, 1'b0);
        chk("mid_rst_res_sum", res_sum, 4'h0);
        chk("mid_rst_res_count", res_count, 4'h0);
        chk("mid_rst_res_err", res_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q = '{4'hF};                    run_frame(0);

        for (int f = 0; f < 30; f++) begin
            n = $urandom_range(1, 18);
            q.delete();
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < n - 1; i++) q.push_back(W'($urandom));
                ck = ~ref_sum();
                q.push_back(ck);
            end else begin
                for (int i = 0; i < n; i++) q.push_back(W'($urandom));
            end
            run_frame($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ones_checksum_checker
`default_nettype wire
